// File: rtl/fc_ctrl_pkg.sv
// rtl/fc_ctrl_pkg.sv - shared types and helpers for the fully-connected layer controller
package fc_ctrl_pkg;

    typedef enum logic [2:0] {
        ACCUM,
        BIAS,
        WAIT,
        DONE,
        CLEAR
    } fc_ctrl_state_t;

    // Latency counter must hold ALU_LATENCY itself; never collapse to zero width.
    function automatic int lat_bits(input int alu_latency);
        return (alu_latency < 1) ? 1 : $clog2(alu_latency + 1);
    endfunction

endpackage

// File: rtl/fc_layer_ctrl_if.sv
// rtl/fc_layer_ctrl_if.sv - upstream, neuron-control and downstream signals of the layer controller
interface fc_layer_ctrl_if #(
    parameter int WORD_SIZE        = 16,
    parameter int RAM_ADDRESS_BITS = 3
);

    logic                        valid_i;
    logic [WORD_SIZE-1:0]        data_i;
    logic                        ready_o;
    logic [RAM_ADDRESS_BITS-1:0] w_addr_o;
    logic [WORD_SIZE-1:0]        data_o;
    logic                        sum_en_o;
    logic                        add_bias_o;
    logic                        acc_clr_o;
    logic                        valid_o;
    logic                        ready_i;

    modport master (
        input  valid_i,
        input  data_i,
        input  ready_i,
        output ready_o,
        output w_addr_o,
        output data_o,
        output sum_en_o,
        output add_bias_o,
        output acc_clr_o,
        output valid_o
    );

    modport slave (
        output valid_i,
        output data_i,
        output ready_i,
        input  ready_o,
        input  w_addr_o,
        input  data_o,
        input  sum_en_o,
        input  add_bias_o,
        input  acc_clr_o,
        input  valid_o
    );

endinterface

// File: rtl/fc_layer_ctrl.sv
// rtl/fc_layer_ctrl.sv - sequencer for one fully-connected layer of fc_neuron instances
module fc_layer_ctrl
    import fc_ctrl_pkg::*;
#(
    parameter int WORD_SIZE             = 16,
    parameter int PREVIOUS_LAYER_HEIGHT = 4,
    parameter int RAM_ADDRESS_BITS      = $clog2(PREVIOUS_LAYER_HEIGHT + 1),
    parameter int ALU_LATENCY           = 1
) (
    input  logic           clk_i,
    input  logic           reset_i,
    fc_layer_ctrl_if.master bus
);

    localparam int LAT_BITS = lat_bits(ALU_LATENCY);
    localparam logic [RAM_ADDRESS_BITS-1:0] LAST_IDX  = RAM_ADDRESS_BITS'(PREVIOUS_LAYER_HEIGHT - 1);
    localparam logic [RAM_ADDRESS_BITS-1:0] BIAS_ADDR = RAM_ADDRESS_BITS'(PREVIOUS_LAYER_HEIGHT);
    localparam logic [LAT_BITS-1:0]         LAT_END   = LAT_BITS'(ALU_LATENCY);

    fc_ctrl_state_t              state, state_nx;
    logic [RAM_ADDRESS_BITS-1:0] cnt, cnt_nx;
    logic [RAM_ADDRESS_BITS-1:0] w_addr, w_addr_nx;
    logic [LAT_BITS-1:0]         lat, lat_nx;
    logic [WORD_SIZE-1:0]        data, data_nx;
    logic                        sum_en, sum_en_nx;
    logic                        add_bias, add_bias_nx;
    logic                        acc_clr, acc_clr_nx;
    logic                        valid, valid_nx;
    logic                        ready;
    logic                        accept;

    assign ready  = (state == ACCUM) && !reset_i;
    assign accept = ready && bus.valid_i;

    // acc_clr resets high so the neurons drop any partial sum on the first post-reset cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= ACCUM;
            cnt      <= '0;
            lat      <= '0;
            w_addr   <= '0;
            data     <= '0;
            sum_en   <= 1'b0;
            add_bias <= 1'b0;
            acc_clr  <= 1'b1;
            valid    <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            lat      <= lat_nx;
            w_addr   <= w_addr_nx;
            data     <= data_nx;
            sum_en   <= sum_en_nx;
            add_bias <= add_bias_nx;
            acc_clr  <= acc_clr_nx;
            valid    <= valid_nx;
        end
    end

    // Registered outputs are computed one cycle ahead, so w_addr leads data/strobes by one cycle
    // and lines up with the neurons' one-cycle ROM read.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        lat_nx      = lat;
        w_addr_nx   = w_addr;
        data_nx     = data;
        sum_en_nx   = 1'b0;
        add_bias_nx = 1'b0;
        acc_clr_nx  = 1'b0;
        valid_nx    = valid;
        case (state)
            ACCUM: begin
                if (accept) begin
                    data_nx   = bus.data_i;
                    sum_en_nx = 1'b1;
                    cnt_nx    = cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state_nx  = BIAS;
                        w_addr_nx = BIAS_ADDR;
                    end else begin
                        w_addr_nx = cnt + 1'b1;
                    end
                end
            end
            BIAS: begin
                add_bias_nx = 1'b1;
                data_nx     = '0;
                lat_nx      = '0;
                state_nx    = WAIT;
            end
            WAIT: begin
                if (lat == LAT_END) begin
                    state_nx = DONE;
                    valid_nx = 1'b1;
                end else begin
                    lat_nx = lat + 1'b1;
                end
            end
            DONE: begin
                if (bus.ready_i) begin
                    state_nx   = CLEAR;
                    valid_nx   = 1'b0;
                    acc_clr_nx = 1'b1;
                end
            end
            CLEAR: begin
                cnt_nx    = '0;
                w_addr_nx = '0;
                state_nx  = ACCUM;
            end
            default: begin
                state_nx = ACCUM;
            end
        endcase
    end

    assign bus.ready_o    = ready;
    assign bus.w_addr_o   = w_addr;
    assign bus.data_o     = data;
    assign bus.sum_en_o   = sum_en;
    assign bus.add_bias_o = add_bias;
    assign bus.acc_clr_o  = acc_clr;
    assign bus.valid_o    = valid;

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// tb/tb_fc_layer_ctrl.sv - self-checking bench for fc_layer_ctrl with behavioural neurons
module tb_fc_layer_ctrl;

    typedef struct {
        int n0;
        int n1;
    } pair_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fc_layer_ctrl_if #(.WORD_SIZE(16), .RAM_ADDRESS_BITS(3)) ifa ();
    fc_layer_ctrl_if #(.WORD_SIZE(16), .RAM_ADDRESS_BITS(1)) ifb ();

    fc_layer_ctrl #(
        .WORD_SIZE(16), .PREVIOUS_LAYER_HEIGHT(4), .RAM_ADDRESS_BITS(3), .ALU_LATENCY(1)
    ) dut_a (
        .clk_i(clk), .reset_i(rst), .bus(ifa)
    );

    fc_layer_ctrl #(
        .WORD_SIZE(16), .PREVIOUS_LAYER_HEIGHT(1), .RAM_ADDRESS_BITS(1), .ALU_LATENCY(3)
    ) dut_b (
        .clk_i(clk), .reset_i(rst), .bus(ifb)
    );

    // Q8.8 weights; entry H is the bias
    int rom0 [8] = '{256, 256, 256, 256, 128, 0, 0, 0};
    int rom1 [8] = '{256, 512, -256, 128, -64, 0, 0, 0};
    int romb [2] = '{256, 128};

    int rq0 = 0, rq1 = 0, rqb = 0;
    int n0_a = 0, n1_a = 0, n_b = 0;

    pair_t sb_a [$];
    int    sb_b [$];

    int a_last_n0 = 0, a_last_n1 = 0, a_last_vlen = 0;
    int a_first_acc = -100, a_clr_cyc = -100;

    function automatic int mulq(input logic signed [15:0] d, input int w);
        return (int'(d) * w) >>> 8;
    endfunction

    function automatic pair_t ref_a(input int x0, input int x1, input int x2, input int x3);
        int    xs [4];
        pair_t r;
        xs   = '{x0, x1, x2, x3};
        r.n0 = rom0[4];
        r.n1 = rom1[4];
        for (int i = 0; i < 4; i++) begin
            r.n0 += mulq(16'(xs[i]), rom0[i]);
            r.n1 += mulq(16'(xs[i]), rom1[i]);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        rq0 <= rom0[ifa.w_addr_o];
        rq1 <= rom1[ifa.w_addr_o];
        if (ifa.acc_clr_o) begin
            n0_a <= 0;
            n1_a <= 0;
        end else if (ifa.add_bias_o) begin
            n0_a <= n0_a + rq0;
            n1_a <= n1_a + rq1;
        end else if (ifa.sum_en_o) begin
            n0_a <= n0_a + mulq(ifa.data_o, rq0);
            n1_a <= n1_a + mulq(ifa.data_o, rq1);
        end
    end

    always_ff @(posedge clk) begin
        rqb <= romb[ifb.w_addr_o];
        if (ifb.acc_clr_o)
            n_b <= 0;
        else if (ifb.add_bias_o)
            n_b <= n_b + rqb;
        else if (ifb.sum_en_o)
            n_b <= n_b + mulq(ifb.data_o, rqb);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic a_send(input int w);
        logic acc;
        int   n;
        n = 0;
        ifa.valid_i = 1'b1;
        ifa.data_i  = 16'(w);
        forever begin
            @(negedge clk);
            acc = ifa.ready_o;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                check("a_send_timeout", 0, 1);
                break;
            end
        end
        ifa.valid_i = 1'b0;
    endtask

    task automatic a_send4(input int x0, input int x1, input int x2, input int x3, input int gap);
        int xs [4];
        xs = '{x0, x1, x2, x3};
        for (int i = 0; i < 4; i++) begin
            a_send(xs[i]);
            if (i < 3) repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain_a();
        for (int i = 0; i < 200 && sb_a.size() != 0; i++) @(posedge clk);
        #1;
        check("a_drain", sb_a.size(), 0);
    endtask

    task automatic wait_valid_a();
        int i;
        i = 0;
        while (!ifa.valid_o && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("a_valid_seen", ifa.valid_o, 1);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_ready"}, ifa.ready_o, 0);
        check({tag, "_addr"}, ifa.w_addr_o, 0);
        check({tag, "_data"}, ifa.data_o, 0);
        check({tag, "_sum_en"}, ifa.sum_en_o, 0);
        check({tag, "_add_bias"}, ifa.add_bias_o, 0);
        check({tag, "_valid"}, ifa.valid_o, 0);
        check({tag, "_acc_clr"}, ifa.acc_clr_o, 1);
    endtask

    // Cycle-level monitor for the H=4 instance: strobe alignment, address walk, latency, scoreboard.
    initial begin : mon_a
        int          idx;
        bit          prev_acc, la1, la2, prev_valid, prev_hs, prev_rst, accept, hs;
        logic [15:0] prev_word;
        int          prev_addr, exp_v, pn0, pn1, sum_cnt, vlen;
        pair_t       e;
        idx = 0; prev_acc = 0; la1 = 0; la2 = 0; prev_valid = 0; prev_hs = 0; prev_rst = 1;
        prev_word = '0; prev_addr = 0; exp_v = -1; pn0 = 0; pn1 = 0; sum_cnt = 0; vlen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                idx = 0; prev_acc = 0; la1 = 0; la2 = 0; prev_valid = 0; prev_hs = 0;
                prev_rst = 1; exp_v = -1; sum_cnt = 0; vlen = 0;
            end else begin
                accept = ifa.valid_i && ifa.ready_o;
                hs     = ifa.valid_o && ifa.ready_i;
                check("a_sum_en", ifa.sum_en_o, prev_acc);
                if (prev_acc) check("a_data", ifa.data_o, prev_word);
                if (ifa.sum_en_o) sum_cnt++;
                check("a_add_bias", ifa.add_bias_o, la2);
                if (ifa.add_bias_o) begin
                    check("a_bias_addr", prev_addr, 4);
                    check("a_bias_data", ifa.data_o, 0);
                    check("a_sum_cnt", sum_cnt, 4);
                    sum_cnt = 0;
                end
                check("a_acc_clr", ifa.acc_clr_o, prev_hs || prev_rst);
                if (ifa.ready_o) check("a_addr", ifa.w_addr_o, idx);
                if (ifa.valid_o) check("a_ready_in_done", ifa.ready_o, 0);
                if (ifa.valid_o && !prev_valid) check("a_valid_lat", cyc, exp_v);
                if (ifa.valid_o && prev_valid) begin
                    check("a_hold_n0", n0_a, pn0);
                    check("a_hold_n1", n1_a, pn1);
                end
                vlen = ifa.valid_o ? vlen + 1 : 0;
                if (hs) begin
                    a_last_n0   = n0_a;
                    a_last_n1   = n1_a;
                    a_last_vlen = vlen;
                    if (sb_a.size() == 0) begin
                        check("a_sb_underflow", 1, 0);
                    end else begin
                        e = sb_a.pop_front();
                        check("a_result_n0", n0_a, e.n0);
                        check("a_result_n1", n1_a, e.n1);
                    end
                end
                if (ifa.acc_clr_o) a_clr_cyc = cyc;
                la2 = la1;
                la1 = accept && (idx == 3);
                if (accept) begin
                    if (idx == 0) a_first_acc = cyc;
                    if (idx == 3) exp_v = cyc + 4;
                    idx = (idx == 3) ? 0 : idx + 1;
                end
                prev_acc   = accept;
                prev_word  = ifa.data_i;
                prev_addr  = int'(ifa.w_addr_o);
                prev_valid = ifa.valid_o;
                pn0        = n0_a;
                pn1        = n1_a;
                prev_hs    = hs;
                prev_rst   = 0;
            end
        end
    end

    // H=1, ALU_LATENCY=3 instance: bias two cycles after accept, valid four cycles after bias.
    initial begin : mon_b
        int b_acc, b_bias;
        bit pv;
        b_acc = -100; b_bias = -100; pv = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ifb.valid_i && ifb.ready_o) begin
                    b_acc = cyc;
                    check("b_addr", ifb.w_addr_o, 0);
                end
                if (ifb.add_bias_o) begin
                    check("b_bias_lat", cyc - b_acc, 2);
                    b_bias = cyc;
                end
                if (ifb.valid_o && !pv) begin
                    check("b_valid_lat", cyc - b_acc, 6);
                    check("b_bias_to_valid", cyc - b_bias, 4);
                end
                if (ifb.valid_o && ifb.ready_i) begin
                    if (sb_b.size() == 0) check("b_sb_underflow", 1, 0);
                    else check("b_result", n_b, sb_b.pop_front());
                end
                pv = ifb.valid_o;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        ifa.valid_i = 1'b0; ifa.data_i = '0; ifa.ready_i = 1'b1;
        ifb.valid_i = 1'b0; ifb.data_i = '0; ifb.ready_i = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_a("rst");
        check("rst_b_ready", ifb.ready_o, 0);
        check("rst_b_acc_clr", ifb.acc_clr_o, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", ifa.ready_o, 1);
        check("post_rst_acc_clr", ifa.acc_clr_o, 1);
        @(posedge clk);
        #1;

        // happy path: 1,2,3,4 back to back
        sb_a.push_back(ref_a(256, 512, 768, 1024));
        a_send4(256, 512, 768, 1024, 0);
        drain_a();
        check("happy_n0", a_last_n0, 2688);
        check("happy_n1", a_last_n1, 960);
        check("happy_valid_len", a_last_vlen, 1);

        // gapped input
        sb_a.push_back(ref_a(256, 512, 768, 1024));
        a_send4(256, 512, 768, 1024, 2);
        drain_a();
        check("gap_n0", a_last_n0, 2688);

        // downstream backpressure for 5 cycles, next inference waiting upstream
        ifa.ready_i = 1'b0;
        sb_a.push_back(ref_a(5 * 256, -2 * 256, 7 * 256, 256));
        a_send4(5 * 256, -2 * 256, 7 * 256, 256, 0);
        wait_valid_a();
        fork
            begin
                sb_a.push_back(ref_a(-256, 3 * 256, 128, 2 * 256));
                a_send4(-256, 3 * 256, 128, 2 * 256, 0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                ifa.ready_i = 1'b1;
            end
        join
        check("bp_valid_len", a_last_vlen, 6);
        check("bp_accept_after_clear", a_first_acc - a_clr_cyc, 1);
        drain_a();

        // reset after 2 of 4 words, then a clean inference
        a_send(9 * 256);
        a_send(9 * 256);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_a("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_post_ready", ifa.ready_o, 1);
        check("midrst_post_acc_clr", ifa.acc_clr_o, 1);
        @(posedge clk);
        #1;
        sb_a.push_back(ref_a(256, 512, 768, 1024));
        a_send4(256, 512, 768, 1024, 0);
        drain_a();
        check("midrst_n0", a_last_n0, 2688);

        // H=1, ALU_LATENCY=3: single word 3
        sb_b.push_back(896);
        ifb.valid_i = 1'b1;
        ifb.data_i  = 16'(768);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!ifb.ready_o && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("b_ready_seen", ifb.ready_o, 1);
            @(posedge clk);
            #1;
            ifb.valid_i = 1'b0;
            for (int i = 0; i < 100 && sb_b.size() != 0; i++) @(posedge clk);
            #1;
            check("b_drain", sb_b.size(), 0);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
